capture_sequencer: RTL and testbench
====================================

Name: capture_sequencer

Overview:
Sequences one LVDS capture into the sample buffer. On request it drives the P12 front-end selects and waits a settle interval. It then optionally waits for a trigger and generates the write address and write enable for exactly N+1 samples. Sits in the LVDS_CLK domain between the CR.START synchroniser and the capture buffer write port, and owns P12_SEL1/P12_SEL3.

Parameters:
ADDR_WIDTH, 9, buffer address width; capture length up to 2**ADDR_WIDTH samples
SETTLE_CYCLES, 16, LVDS_CLK cycles between select assertion and arming (>=1)
TIMEOUT_CYCLES, 65535, ARMED-state trigger timeout; used only with the optional feature

Ports:
LVDS_CLK  in  1  sole clock
LVDS_RESET  in  1  synchronous reset, active-high
start  in  1  one-cycle capture request, already synchronised
abort  in  1  one-cycle abort request
trig  in  1  external trigger, already synchronised, level sampled
cfg_len  in  ADDR_WIDTH  samples-1 to capture
cfg_sel  in  2  bit0 enables P12_SEL1, bit1 enables P12_SEL3
cfg_trig_en  in  1  1 = wait for trig, 0 = capture immediately after settle
done_ack  in  1  clears done, returns to IDLE
wr_addr  out  ADDR_WIDTH  buffer write address
wr_en  out  1  buffer write enable
P12_SEL1  out  1  front-end select 1
P12_SEL3  out  1  front-end select 3
busy  out  1  high in SETTLE/ARMED/CAPTURE
done  out  1  high in DONE
aborted  out  1  one-cycle pulse when abort takes effect
timeout  out  1  one-cycle pulse on trigger timeout (0 without feature)

Behaviour:
- Synchronous reset: state IDLE, counters 0. All outputs 0, wr_addr 0. Reset overrides every input, including mid-capture.
- Moore outputs decoded from registered state/counters. wr_en = (state==CAPTURE). wr_addr = sample counter. busy/done by state.
- P12_SEL1 = cfg_sel_q[0] & (state in SETTLE/ARMED/CAPTURE). P12_SEL3 = cfg_sel_q[1] & same. Both are 0 in IDLE and DONE.
- IDLE: on start=1, latch cfg_len, cfg_sel, cfg_trig_en into _q registers and go to SETTLE next cycle. Clear settle counter. start is ignored in every other state. Config inputs are not sampled outside this accept cycle.
- SETTLE: the settle counter increments each cycle. After SETTLE_CYCLES cycles in SETTLE, go to ARMED if cfg_trig_en_q, else to CAPTURE. Sample counter is cleared on exit.
- ARMED: trig=1 -> CAPTURE next cycle. The trigger cycle itself does not write.
- CAPTURE: wr_en=1 each cycle, and wr_addr increments by 1 each cycle starting at 0. The cycle with wr_addr==cfg_len_q is written, then DONE follows. Total writes = cfg_len_q+1. cfg_len_q = 2**ADDR_WIDTH-1 fills the buffer with no wrap. wr_addr never wraps.
- DONE: done=1 and wr_addr holds its last value. done_ack=1 -> IDLE next cycle. start is ignored until IDLE.
- abort: in SETTLE/ARMED/CAPTURE, go to IDLE next cycle and pulse aborted for one cycle. Selects drop and done is not set. abort has priority over trig, settle expiry and capture end in the same cycle. abort in IDLE/DONE is ignored.
- start and abort in the same IDLE cycle: start is accepted.
- done_ack outside DONE is ignored.

Optional Feature:
CAPTURE_SEQUENCER_TIMEOUT_EN.
- Defined: ARMED runs a counter cleared on entry. If it reaches TIMEOUT_CYCLES without trig, go to IDLE and pulse timeout for one cycle. trig arriving on the expiry cycle wins and goes to CAPTURE. abort still has top priority.
- Undefined: ARMED waits indefinitely, no timeout counter is built, and timeout is tied 0.

Decomposition:
- Shared package capture_pkg: state encoding localparams (ST_IDLE, ST_SETTLE, ST_ARMED, ST_CAPTURE, ST_DONE) and the cfg_sel bit indices.
- One natural sub-module: capture_seq_counter. It is a loadable, clearable up-counter with a terminal-compare output, instanced for the settle, sample and timeout counters.

Test Plan:
- Immediate capture: cfg_len=7, cfg_sel=2'b11, cfg_trig_en=0, start pulse -> selects high after 1 cycle; wr_en high for 8 cycles starting SETTLE_CYCLES+1 cycles after start; wr_addr 0..7; done=1; done_ack -> IDLE with all outputs 0.
- Triggered capture: cfg_trig_en=1, cfg_sel=2'b01, trig 40 cycles after arming -> no wr_en before trig; first write 1 cycle after trig; only P12_SEL1 high; start mid-capture ignored.
- Full depth: cfg_len=511 -> exactly 512 writes, last wr_addr=511, no wrap, done asserted.
- Abort priority: abort on the same cycle as trig, and separately on the cycle with wr_addr==cfg_len -> IDLE, aborted pulse, done stays 0, selects 0.
- Reset mid-CAPTURE at wr_addr=100 -> next cycle all outputs 0, state IDLE; a new start captures from wr_addr 0.
- With CAPTURE_SEQUENCER_TIMEOUT_EN, TIMEOUT_CYCLES=20, no trig -> timeout pulse after 20 ARMED cycles, then IDLE. trig on the 20th cycle -> CAPTURE instead, no timeout pulse.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared definitions for the LVDS capture sequencer: FSM state encoding and
// the bit positions of the front-end select enables inside cfg_sel.
package capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_ARMED   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int SEL1_IDX = 0;
  localparam int SEL3_IDX = 1;

endpackage

// File: rtl/capture_seq_counter.sv
// Loadable, clearable up-counter with an equality compare against a terminal
// value; used for the settle, sample and trigger-timeout counts.
module capture_seq_counter #(
  parameter int WIDTH = 8
) (
  input  logic             LVDS_CLK,
  input  logic             LVDS_RESET,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic             at_term
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge LVDS_CLK) begin
    if (LVDS_RESET || clr) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (inc) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count   = count_reg;
  assign at_term = (count_reg == term);

endmodule

// File: rtl/capture_sequencer.sv
// Sequences one LVDS capture: front-end selects, settle wait, optional trigger
// wait, then N+1 buffer writes. Define CAPTURE_SEQUENCER_TIMEOUT_EN for the ARMED timeout.
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int ADDR_WIDTH     = 9,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  LVDS_CLK,
  input  logic                  LVDS_RESET,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  trig,
  input  logic [ADDR_WIDTH-1:0] cfg_len,
  input  logic [1:0]            cfg_sel,
  input  logic                  cfg_trig_en,
  input  logic                  done_ack,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_en,
  output logic                  P12_SEL1,
  output logic                  P12_SEL3,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  timeout
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_TERM = SW'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("capture_sequencer: SETTLE_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cfg_len_q;
  logic [1:0]            cfg_sel_q;
  logic                  cfg_trig_en_q;
  logic                  aborted_reg, aborted_next;
  logic                  in_busy, accept;
  logic                  settle_done, sample_last;
  logic                  sample_clr, sample_inc;
  logic [SW-1:0]         settle_cnt_unused;
  logic [ADDR_WIDTH-1:0] sample_count;

  assign accept  = (state_reg == ST_IDLE) && start;
  assign in_busy = (state_reg == ST_SETTLE) || (state_reg == ST_ARMED) ||
                   (state_reg == ST_CAPTURE);

  capture_seq_counter #(.WIDTH(SW)) u_settle_cnt (
    .LVDS_CLK  (LVDS_CLK),
    .LVDS_RESET(LVDS_RESET),
    .clr       (state_reg != ST_SETTLE),
    .load      (1'b0),
    .load_val  ('0),
    .inc       (state_reg == ST_SETTLE),
    .term      (SETTLE_TERM),
    .count     (settle_cnt_unused),
    .at_term   (settle_done)
  );

  // Held at zero outside CAPTURE/DONE so wr_addr starts each capture at 0 and
  // holds its final value while DONE waits for the acknowledge.
  assign sample_clr = (state_next != ST_CAPTURE) && (state_next != ST_DONE);
  assign sample_inc = (state_reg == ST_CAPTURE) && (state_next == ST_CAPTURE);

  capture_seq_counter #(.WIDTH(ADDR_WIDTH)) u_sample_cnt (
    .LVDS_CLK  (LVDS_CLK),
    .LVDS_RESET(LVDS_RESET),
    .clr       (sample_clr),
    .load      (1'b0),
    .load_val  ('0),
    .inc       (sample_inc),
    .term      (cfg_len_q),
    .count     (sample_count),
    .at_term   (sample_last)
  );

`ifdef CAPTURE_SEQUENCER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          armed_expired;
  logic          timeout_reg, timeout_next;
  logic [TW-1:0] armed_cnt_unused;

  capture_seq_counter #(.WIDTH(TW)) u_timeout_cnt (
    .LVDS_CLK  (LVDS_CLK),
    .LVDS_RESET(LVDS_RESET),
    .clr       (state_reg != ST_ARMED),
    .load      (1'b0),
    .load_val  ('0),
    .inc       (state_reg == ST_ARMED),
    .term      (TW'(TIMEOUT_CYCLES - 1)),
    .count     (armed_cnt_unused),
    .at_term   (armed_expired)
  );

  always_ff @(posedge LVDS_CLK) begin
    if (LVDS_RESET) begin
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= timeout_next;
    end
  end

  assign timeout = timeout_reg;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge LVDS_CLK) begin
    if (LVDS_RESET) begin
      state_reg     <= ST_IDLE;
      aborted_reg   <= 1'b0;
      cfg_len_q     <= '0;
      cfg_sel_q     <= '0;
      cfg_trig_en_q <= 1'b0;
    end else begin
      state_reg   <= state_next;
      aborted_reg <= aborted_next;
      if (accept) begin
        cfg_len_q     <= cfg_len;
        cfg_sel_q     <= cfg_sel;
        cfg_trig_en_q <= cfg_trig_en;
      end
    end
  end

  // abort is checked first in every busy state so it beats trig, settle
  // expiry, trigger timeout and the final sample.
  always_comb begin
    state_next   = state_reg;
    aborted_next = 1'b0;
`ifdef CAPTURE_SEQUENCER_TIMEOUT_EN
    timeout_next = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (abort) begin
          state_next   = ST_IDLE;
          aborted_next = 1'b1;
        end else if (settle_done) begin
          state_next = cfg_trig_en_q ? ST_ARMED : ST_CAPTURE;
        end
      end
      ST_ARMED: begin
        if (abort) begin
          state_next   = ST_IDLE;
          aborted_next = 1'b1;
        end else if (trig) begin
          state_next = ST_CAPTURE;
`ifdef CAPTURE_SEQUENCER_TIMEOUT_EN
        end else if (armed_expired) begin
          state_next   = ST_IDLE;
          timeout_next = 1'b1;
`endif
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          state_next   = ST_IDLE;
          aborted_next = 1'b1;
        end else if (sample_last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (done_ack) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign wr_en    = (state_reg == ST_CAPTURE);
  assign wr_addr  = sample_count;
  assign busy     = in_busy;
  assign done     = (state_reg == ST_DONE);
  assign aborted  = aborted_reg;
  assign P12_SEL1 = cfg_sel_q[SEL1_IDX] & in_busy;
  assign P12_SEL3 = cfg_sel_q[SEL3_IDX] & in_busy;

endmodule

// File: tb/tb_capture_sequencer.sv
// Randomised scoreboard bench for capture_sequencer; expected writes and pulses
// are derived from cycle arithmetic on the capture rules, checked by a monitor.
module tb_capture_sequencer;

  localparam int AW = 9;
  localparam int S  = 16;
  localparam int T  = 20;
  localparam int OW = AW + 5;

  logic          LVDS_CLK = 1'b0;
  logic          LVDS_RESET = 1'b1;
  logic          start = 1'b0, abort = 1'b0, trig = 1'b0, done_ack = 1'b0;
  logic [AW-1:0] cfg_len = '0;
  logic [1:0]    cfg_sel = '0;
  logic          cfg_trig_en = 1'b0;
  logic [AW-1:0] wr_addr;
  logic          wr_en, P12_SEL1, P12_SEL3, busy, done, aborted, timeout;

  capture_sequencer #(.ADDR_WIDTH(AW), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .LVDS_CLK(LVDS_CLK), .LVDS_RESET(LVDS_RESET), .start(start), .abort(abort),
    .trig(trig), .cfg_len(cfg_len), .cfg_sel(cfg_sel), .cfg_trig_en(cfg_trig_en),
    .done_ack(done_ack), .wr_addr(wr_addr), .wr_en(wr_en), .P12_SEL1(P12_SEL1),
    .P12_SEL3(P12_SEL3), .busy(busy), .done(done), .aborted(aborted), .timeout(timeout)
  );

  always #5 LVDS_CLK = ~LVDS_CLK;

  int cyc = 0;
  always @(posedge LVDS_CLK) cyc <= cyc + 1;

  typedef enum int {EV_WRITE, EV_DONE, EV_ABORT, EV_TIMEOUT} ev_kind_t;
  typedef struct { ev_kind_t kind; int cyc; int addr; int sel; } ev_t;
  typedef struct { int cyc; logic [OW-1:0] outs; logic [OW-1:0] mask; } snap_t;

  ev_t   exp_q[$];
  snap_t snap_q[$];
  int    n_vec = 0;
  int    n_fail = 0;
  bit    finished = 0;
  bit    mon_done_d = 0;

  function automatic void want_ev(ev_kind_t k, int c, int a, int s);
    ev_t e;
    e.kind = k; e.cyc = c; e.addr = a; e.sel = s;
    exp_q.push_back(e);
  endfunction

  // Snapshot of {wr_en, wr_addr, sel3, sel1, busy, done}; wr_en and done are 0
  // at every point where a snapshot is taken.
  function automatic void want_snap(int c, logic [1:0] sel, logic b, bit addr_known);
    snap_t s;
    s.cyc  = c;
    s.outs = {1'b0, {AW{1'b0}}, sel, b, 1'b0};
    s.mask = '1;
    if (!addr_known) s.mask[AW+3:4] = '0;
    snap_q.push_back(s);
  endfunction

  task automatic pop_cmp(input ev_kind_t k, input int a, input int s);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event: got %s@%0d addr=%0d sel=%0d, required nothing", k.name(), cyc, a, s);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || (k == EV_WRITE && (e.addr != a || e.sel != s))) begin
        n_fail++;
        $display("FAIL event: got %s@%0d addr=%0d sel=%0d, required %s@%0d addr=%0d sel=%0d",
                 k.name(), cyc, a, s, e.kind.name(), e.cyc, e.addr, e.sel);
      end
    end
  endtask

  // Monitor: the only process that touches the counters.
  initial begin
    snap_t         sp;
    logic [OW-1:0] outs;
    forever begin
      @(negedge LVDS_CLK);
      if (wr_en === 1'b1) pop_cmp(EV_WRITE, int'(wr_addr), int'({P12_SEL3, P12_SEL1}));
      if (done === 1'b1 && !mon_done_d) pop_cmp(EV_DONE, 0, 0);
      if (aborted === 1'b1) pop_cmp(EV_ABORT, 0, 0);
      if (timeout === 1'b1) pop_cmp(EV_TIMEOUT, 0, 0);
      mon_done_d = (done === 1'b1);
      outs = {wr_en, wr_addr, P12_SEL3, P12_SEL1, busy, done};
      while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
        sp = snap_q.pop_front();
        n_vec++;
        if (sp.cyc != cyc || (outs & sp.mask) !== (sp.outs & sp.mask)) begin
          n_fail++;
          $display("FAIL snapshot@%0d: got outs=%h, required %h (mask %h) at cycle %0d",
                   cyc, outs, sp.outs, sp.mask, sp.cyc);
        end
      end
      if (finished) begin
        n_vec++;
        if (exp_q.size() != 0) begin
          n_fail++;
          $display("FAIL pending_events: got %0d never seen, required 0 (next %s@%0d)",
                   exp_q.size(), exp_q[0].kind.name(), exp_q[0].cyc);
        end
        n_vec++;
        if (snap_q.size() != 0) begin
          n_fail++;
          $display("FAIL pending_snapshots: got %0d, required 0", snap_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge LVDS_CLK);
    #1;
  endtask

  task automatic idle_noise(input int n);
    for (int k = 0; k < n; k++) begin
      start = 1'b0;
      abort = 1'($urandom); done_ack = 1'($urandom); trig = 1'($urandom);
      cfg_len = AW'($urandom); cfg_sel = 2'($urandom); cfg_trig_en = 1'($urandom);
      want_snap(cyc, 2'b00, 1'b0, 1'b0);
      tick();
    end
    {start, abort, done_ack, trig} = '0;
  endtask

  // One capture issued at the current cycle s. abort_rel<0 means no abort,
  // otherwise abort is driven at cycle s+1+abort_rel (clamped to the last busy cycle).
  task automatic run_capture(input int len, input logic [1:0] sel, input bit trig_en,
                             input int tdel, input int abort_rel, input int ack_del,
                             input bit abort_with_start);
    int s, arm, tt, cap0, last_busy, a, d, endc, arm_end;
    bit to, normal, armed_win;
    s = cyc; arm = s + S + 1; tt = -1; to = 0; arm_end = -1;
    if (trig_en) begin
`ifdef CAPTURE_SEQUENCER_TIMEOUT_EN
      to = (tdel >= T);
`endif
      if (to) begin
        arm_end = arm + T - 1;
        cap0 = arm + T;
      end else begin
        tt = arm + tdel;
        arm_end = tt;
        cap0 = tt + 1;
      end
    end else begin
      cap0 = arm;
    end
    last_busy = to ? arm_end : cap0 + len;
    a = (abort_rel < 0) ? -1 : s + 1 + abort_rel;
    if (a > last_busy) a = last_busy;
    normal = (a < 0) && !to;
    d = normal ? cap0 + len + 1 : last_busy + 1;

    want_snap(s + 1, sel, 1'b1, 1'b1);
    if (!to) begin
      for (int i = 0; i <= len; i++)
        if (a < 0 || cap0 + i <= a) want_ev(EV_WRITE, cap0 + i, i, int'(sel));
    end
    if (a >= 0) begin
      want_ev(EV_ABORT, a + 1, 0, 0);
      endc = a;
    end else if (to) begin
      want_ev(EV_TIMEOUT, arm + T, 0, 0);
      endc = arm_end;
    end else begin
      want_ev(EV_DONE, d, 0, 0);
      endc = d + ack_del;
    end
    want_snap(endc + 1, 2'b00, 1'b0, normal);

    cfg_len = AW'(len); cfg_sel = sel; cfg_trig_en = trig_en;
    start = 1'b1; abort = abort_with_start; trig = 1'b0; done_ack = 1'b0;
    tick();
    for (int c = s + 1; c <= endc; c++) begin
      armed_win = trig_en && c >= arm && c <= arm_end;
      start = ($urandom_range(4) == 0);
      cfg_len = AW'($urandom); cfg_sel = 2'($urandom); cfg_trig_en = 1'($urandom);
      trig = (c == tt) || (!armed_win && $urandom_range(5) == 0);
      abort = (c == a) || (normal && c >= d && $urandom_range(3) == 0);
      done_ack = (normal && c == endc) || (c < d && $urandom_range(4) == 0);
      tick();
    end
    {start, abort, done_ack, trig} = '0;
    idle_noise($urandom_range(3));
  endtask

  // Reset asserted on the cycle that writes address 100 of a 301-sample capture.
  task automatic run_reset_mid();
    int s, cap0, rc;
    s = cyc; cap0 = s + S + 1; rc = cap0 + 100;
    want_snap(s + 1, 2'b10, 1'b1, 1'b1);
    for (int i = 0; i <= 100; i++) want_ev(EV_WRITE, cap0 + i, i, 2);
    want_snap(rc + 1, 2'b00, 1'b0, 1'b1);
    cfg_len = AW'(300); cfg_sel = 2'b10; cfg_trig_en = 1'b0; start = 1'b1;
    tick();
    for (int c = s + 1; c <= rc; c++) begin
      start = ($urandom_range(4) == 0);
      LVDS_RESET = (c == rc);
      tick();
    end
    LVDS_RESET = 1'b0; start = 1'b0;
  endtask

  initial begin
    int len, tdel, arel;
    LVDS_RESET = 1'b1;
    repeat (3) tick();
    want_snap(cyc, 2'b00, 1'b0, 1'b1);
    tick();
    LVDS_RESET = 1'b0;
    want_snap(cyc, 2'b00, 1'b0, 1'b1);
    tick();

    run_capture(7, 2'b11, 1'b0, 0, -1, 2, 1'b0);
`ifdef CAPTURE_SEQUENCER_TIMEOUT_EN
    run_capture(20, 2'b01, 1'b1, T - 1, -1, 1, 1'b0);
    run_capture(5, 2'b11, 1'b1, T, -1, 0, 1'b0);
`else
    run_capture(20, 2'b01, 1'b1, 40, -1, 1, 1'b0);
`endif
    run_capture(511, 2'b10, 1'b0, 0, -1, 3, 1'b0);
    run_capture(9, 2'b11, 1'b1, 5, S + 5, 0, 1'b0);
    run_capture(10, 2'b01, 1'b0, 0, S + 10, 0, 1'b0);
    run_capture(3, 2'b11, 1'b0, 0, -1, 0, 1'b1);

    for (int n = 0; n < 25; n++) begin
      len = ($urandom_range(3) == 0) ? int'($urandom_range(511)) : int'($urandom_range(40));
`ifdef CAPTURE_SEQUENCER_TIMEOUT_EN
      tdel = int'($urandom_range(T + 3));
`else
      tdel = int'($urandom_range(60));
`endif
      arel = ($urandom_range(3) == 0) ? int'($urandom_range(S + len + tdel + 4)) : -1;
      run_capture(len, 2'($urandom), 1'($urandom), tdel, arel,
                  int'($urandom_range(3)), ($urandom_range(3) == 0));
    end

    run_reset_mid();
    run_capture(4, 2'b11, 1'b0, 0, -1, 0, 1'b0);
    idle_noise(3);
    finished = 1;
  end

endmodule
